// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined unsigned WIDTH x WIDTH Urdhva Tiryagbhyam multiplier
// with valid/ready handshake on both sides and a single global advance.
module vedic_mult_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 pipe_empty
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned MW = WIDTH + 1;

    // operand halves
    logic [H-1:0] a_hi, a_lo, b_hi, b_lo;

    // stage 1: crosswise sub-products
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] ll1_q, ll1_d, lh1_q, lh1_d, hl1_q, hl1_d, hh1_q, hh1_d;

    // stage 2: crosswise sum plus pass-through
    logic             v2_q, v2_d;
    logic [MW-1:0]    mid2_q, mid2_d;
    logic [WIDTH-1:0] ll2_q, ll2_d, hh2_q, hh2_d;

    // stage 3: final product
    logic             v3_q, v3_d;
    logic [PW-1:0]    p3_q, p3_d;

    logic adv;

    assign a_hi = a[WIDTH-1:H];
    assign a_lo = a[H-1:0];
    assign b_hi = b[WIDTH-1:H];
    assign b_lo = b[H-1:0];

    // the whole pipe moves together whenever the output slot can be vacated
    assign adv        = !v3_q || out_ready;
    assign in_ready   = adv;
    assign out_valid  = v3_q;
    assign p          = p3_q;
    assign pipe_empty = !(v1_q || v2_q || v3_q);

    // next-state for all stages: hold by default, shift on adv
    always_comb begin
        v1_d   = v1_q;
        ll1_d  = ll1_q;
        lh1_d  = lh1_q;
        hl1_d  = hl1_q;
        hh1_d  = hh1_q;
        v2_d   = v2_q;
        mid2_d = mid2_q;
        ll2_d  = ll2_q;
        hh2_d  = hh2_q;
        v3_d   = v3_q;
        p3_d   = p3_q;
        if (adv) begin
            v1_d   = in_valid;
            ll1_d  = WIDTH'(a_lo) * WIDTH'(b_lo);
            lh1_d  = WIDTH'(a_lo) * WIDTH'(b_hi);
            hl1_d  = WIDTH'(a_hi) * WIDTH'(b_lo);
            hh1_d  = WIDTH'(a_hi) * WIDTH'(b_hi);

            v2_d   = v1_q;
            mid2_d = MW'(lh1_q) + MW'(hl1_q);
            ll2_d  = ll1_q;
            hh2_d  = hh1_q;

            v3_d   = v2_q;
            p3_d   = {hh2_q, ll2_q} + (PW'(mid2_q) << H);
        end
    end

    // pipeline registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            ll1_q  <= '0;
            lh1_q  <= '0;
            hl1_q  <= '0;
            hh1_q  <= '0;
            v2_q   <= 1'b0;
            mid2_q <= '0;
            ll2_q  <= '0;
            hh2_q  <= '0;
            v3_q   <= 1'b0;
            p3_q   <= '0;
        end else begin
            v1_q   <= v1_d;
            ll1_q  <= ll1_d;
            lh1_q  <= lh1_d;
            hl1_q  <= hl1_d;
            hh1_q  <= hh1_d;
            v2_q   <= v2_d;
            mid2_q <= mid2_d;
            ll2_q  <= ll2_d;
            hh2_q  <= hh2_d;
            v3_q   <= v3_d;
            p3_q   <= p3_d;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe (WIDTH=8): directed vectors plus a
// short randomized handshake run; a monitor pops expected products on output.
module tb_vedic_mult_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p;
    logic          pipe_empty;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [PW-1:0] exp_q[$];
    int            stamp_q[$];
    logic          stall_prev = 1'b0;
    logic [PW-1:0] p_prev = '0;
    bit            rnd_done;

    vedic_mult_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .pipe_empty(pipe_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one pair and hold it until accepted; expected product queued on transfer
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [PW-1:0] e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        check("send_accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // output monitor: product compare, stall stability and backpressure checks
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (stall_prev) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_p", 64'(p), 64'(p_prev));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("product", 64'(p), 64'(exp_q.pop_front()));
                    stamp_q.push_back(cyc);
                end
            end
            stall_prev = out_valid && !out_ready;
            p_prev     = p;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int seen;
        int spurious;
        logic [W-1:0] x, y;

        // reset held two cycles with in_valid asserted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        a         = 8'hAA;
        b         = 8'h55;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_pipe_empty", 64'(pipe_empty), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        // single op: result three cycles after acceptance, for one cycle only
        send(8'hFF, 8'hFF, 16'hFE01);
        step();
        step();
        check("lat3_out_valid", 64'(out_valid), 64'd1);
        check("lat3_p", 64'(p), 64'hFE01);
        step();
        check("single_one_cycle", 64'(out_valid), 64'd0);
        drain();

        // streaming back-to-back: products on consecutive cycles
        stamp_q.delete();
        send(8'd3,   8'd5,   16'd15);
        send(8'd0,   8'd200, 16'd0);
        send(8'd255, 8'd1,   16'd255);
        send(8'd16,  8'd16,  16'd256);
        drain();
        check("stream_count", 64'(stamp_q.size()), 64'd4);
        if (stamp_q.size() == 4)
            for (int i = 1; i < 4; i++)
                check("stream_consecutive", 64'(stamp_q[i] - stamp_q[i-1]), 64'd1);

        // backpressure: out_ready low for 4 cycles after the first product
        stamp_q.delete();
        fork
            begin
                send(8'd12,  8'd34,  16'd408);
                send(8'd200, 8'd100, 16'd20000);
                send(8'd255, 8'd254, 16'd64770);
                send(8'd7,   8'd9,   16'd63);
                send(8'd128, 8'd2,   16'd256);
            end
            begin
                seen = 0;
                for (int i = 0; i < 20 && seen == 0; i++) begin
                    @(negedge clk);
                    seen = int'(out_valid);
                end
                check("bp_first_product", 64'(seen), 64'd1);
                step();
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) step();
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(stamp_q.size()), 64'd5);

        // reset mid-flight discards both in-flight pairs
        send(8'd3, 8'd4, 16'd12);
        send(8'd5, 8'd6, 16'd30);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        check("midrst_pipe_empty", 64'(pipe_empty), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) spurious++;
        end
        check("midrst_no_product", 64'(spurious), 64'd0);

        // boundary pairs
        send(8'd0,   8'd0,   16'd0);
        send(8'hFF,  8'd1,   16'h00FF);
        send(8'h0F,  8'hF0,  16'h0E10);
        send(8'hF0,  8'h0F,  16'h0E10);
        drain();

        // randomized handshake with bubbles and backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    x = W'($urandom);
                    y = W'($urandom);
                    send(x, y, PW'(x) * PW'(y));
                    if ($urandom_range(0, 3) == 0) step();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain();
        step();
        check("final_pipe_empty", 64'(pipe_empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
